zxbus_fifo_slave: RTL



---
 rtl/zxbus_pkg.sv | 48 ++++
 rtl/zxbus_wfifo.sv | 72 +++++++
 rtl/zxbus_fifo_slave.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/zxbus_pkg.sv
// Shared definitions for the ZX-bus FIFO slave.
//   - regsel encoding of the four decoded I/O ports
//   - bit positions of the CTRL write register and the STATUS read register
//   - write-queue entry layout and the status packing helper
package zxbus_pkg;

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_A    = 2'd1,
        REG_B    = 2'd2,
        REG_C    = 2'd3
    } regsel_e;

    // CTRL register (write to regsel 0)
    localparam int CTRL_INIT   = 7;
    localparam int CTRL_LED    = 6;
    localparam int CTRL_CLROVF = 5;

    // STATUS register (read from regsel 0); bits 3..0 hold the FIFO count
    localparam int ST_INIT_BUSY = 7;
    localparam int ST_FULL      = 6;
    localparam int ST_EMPTY     = 5;
    localparam int ST_OVF       = 4;

    typedef struct packed {
        regsel_e    sel;
        logic [7:0] data;
    } wq_entry_t;

    localparam int WQ_ENTRY_W = $bits(wq_entry_t);

    // The count field is only four bits wide, so a 16-deep FIFO reports 15 when full.
    function automatic logic [7:0] pack_status(input logic       init_busy,
                                               input logic       full,
                                               input logic       empty,
                                               input logic       ovf,
                                               input logic [4:0] count);
        logic [7:0] st;
        st               = '0;
        st[ST_INIT_BUSY] = init_busy;
        st[ST_FULL]      = full;
        st[ST_EMPTY]     = empty;
        st[ST_OVF]       = ovf;
        st[3:0]          = count[4] ? 4'hF : count[3:0];
        return st;
    endfunction

endpackage

// File: rtl/zxbus_wfifo.sv
// Synchronous write FIFO for the ZX-bus slave.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            empties the FIFO; wins over a simultaneous push or pop
//   push, push_data  enqueue request and entry
//   pop              dequeue request (ignored while empty)
//   head             entry at the read pointer
//   count            occupancy 0..DEPTH
//   full, empty      occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module zxbus_wfifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/zxbus_fifo_slave.sv
// ZX-bus I/O slave with a write FIFO.
// Decodes four ZX I/O ports, drives the external 74HCT245 buffer and IORQGE,
// queues data-port writes for the backend and serves reads from backend bytes
// or the live status register.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   zxid                        ZX data bus (driven only during a decoded read)
//   zxa                         ZX address A7..A0
//   zxiorq_n, zxrd_n, zxwr_n    ZX strobes, asynchronous to clk
//   zxblkiorq_n                 low while the address matches (combinational)
//   zxbusin, zxbusena_n         245 direction (1 = from ZX) and enable (active low)
//   init, init_in_progress      one-cycle init pulse, backend init busy flag
//   led                         LED state
//   wq_valid/ready/sel/data     write-queue head handshake
//   rd_strobe, rd_sel, rd_bytes backend read handshake; byte k-1 serves regsel k
module zxbus_fifo_slave
    import zxbus_pkg::*;
#(
    parameter logic [7:0] ADDR_BASE   = 8'h33,
    parameter logic [7:0] ADDR_MASK   = 8'h77,
    parameter int         SYNC_STAGES = 2,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         FIFO_AW     = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire  [7:0]  zxid,
    input  logic [7:0]  zxa,
    input  logic        zxiorq_n,
    input  logic        zxrd_n,
    input  logic        zxwr_n,
    output logic        zxblkiorq_n,
    output logic        zxbusin,
    output logic        zxbusena_n,
    output logic        init,
    input  logic        init_in_progress,
    output logic        led,
    output logic        wq_valid,
    input  logic        wq_ready,
    output logic [1:0]  wq_sel,
    output logic [7:0]  wq_data,
    output logic        rd_strobe,
    output logic [1:0]  rd_sel,
    input  logic [23:0] rd_bytes
);

    // ---------------------------------------------------------------- decode
    logic    match;
    regsel_e regsel;

    assign match       = ((zxa & ADDR_MASK) == ADDR_BASE);
    assign regsel      = regsel_e'({zxa[7], zxa[3]});
    assign zxblkiorq_n = ~match;

    // ------------------------------------------------- strobe synchronisers
    logic                 iowr_raw;
    logic                 iord_raw;
    logic [SYNC_STAGES:0] iowr_s;
    logic [SYNC_STAGES:0] iord_s;
    logic                 iowr_begin;
    logic                 iowr_end;
    logic                 iord_begin;
    logic                 iord_end;
    logic                 wr_hit;
    logic                 rd_hit;

    assign iowr_raw = ~(zxiorq_n | zxwr_n);
    assign iord_raw = ~(zxiorq_n | zxrd_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iowr_s <= '0;
            iord_s <= '0;
        end else begin
            // NOTE: non-blocking so every stage shifts from the previous cycle's value.
            iowr_s <= {iowr_s[SYNC_STAGES-1:0], iowr_raw};
            iord_s <= {iord_s[SYNC_STAGES-1:0], iord_raw};
        end
    end

    // The extra flop past the synchroniser gives a clean rising/falling pattern.
    assign iowr_begin = iowr_s[SYNC_STAGES-1] & ~iowr_s[SYNC_STAGES];
    assign iowr_end   = ~iowr_s[SYNC_STAGES-1] & iowr_s[SYNC_STAGES];
    assign iord_begin = iord_s[SYNC_STAGES-1] & ~iord_s[SYNC_STAGES];
    assign iord_end   = ~iord_s[SYNC_STAGES-1] & iord_s[SYNC_STAGES];

    // Address must match when the access is first seen; later address changes are ignored.
    assign wr_hit = iowr_begin & match;
    assign rd_hit = iord_begin & match;

    // ------------------------------------------------------------ write FIFO
    logic             ovf;
    logic             push_pend;
    wq_entry_t        push_entry;
    wq_entry_t        head;
    logic             pop;
    logic             full;
    logic             empty;
    logic [FIFO_AW:0] count;

    assign pop      = wq_valid & wq_ready;
    assign wq_valid = ~empty;
    assign wq_sel   = head.sel;
    assign wq_data  = head.data;

    zxbus_wfifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW),
        .W     (WQ_ENTRY_W)
    ) u_wfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (init),
        .push      (push_pend),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // ------------------------------------------------------------- read mux
    logic [7:0] rd_mux;

    always_comb begin
        // NOTE: default first so no path through the case leaves rd_mux unassigned.
        rd_mux = pack_status(init_in_progress, full, empty, ovf, 5'(count));
        case (regsel)
            REG_A:   rd_mux = rd_bytes[7:0];
            REG_B:   rd_mux = rd_bytes[15:8];
            REG_C:   rd_mux = rd_bytes[23:16];
            default: ;
        endcase
    end

    // ------------------------------------------------ buffer and data drive
    logic       zxid_oe;
    logic [7:0] zxid_out;

    assign zxid = zxid_oe ? zxid_out : 8'hzz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zxbusena_n <= 1'b1;
            zxbusin    <= 1'b1;
            zxid_oe    <= 1'b0;
            zxid_out   <= '0;
        end else if (wr_hit || rd_hit) begin
            zxbusena_n <= 1'b0;
            zxbusin    <= ~iord_begin;
            zxid_oe    <= iord_begin;
            if (rd_hit) begin
                zxid_out <= rd_mux;
            end
        end else if (iowr_end || iord_end) begin
            zxbusena_n <= 1'b1;
            zxid_oe    <= 1'b0;
        end
    end

    // -------------------------------------------- control writes and enqueue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init       <= 1'b0;
            led        <= 1'b0;
            ovf        <= 1'b0;
            push_pend  <= 1'b0;
            push_entry <= '0;
        end else begin
            init      <= 1'b0;
            push_pend <= 1'b0;
            if (wr_hit) begin
                if (regsel == REG_CTRL) begin
                    init <= zxid[CTRL_INIT];
                    if (zxid[CTRL_LED]) begin
                        led <= ~led;
                    end
                    if (zxid[CTRL_CLROVF]) begin
                        ovf <= 1'b0;
                    end
                end else begin
                    // Data is latched at begin and pushed one cycle later.
                    push_pend  <= 1'b1;
                    push_entry <= '{sel: regsel, data: zxid};
                end
            end
            // Dropped byte: full with no pop freeing a slot this cycle.
            if (push_pend && full && !pop) begin
                ovf <= 1'b1;
            end
            // The init pulse also flushes the FIFO, so it clears everything it owns here.
            if (init) begin
                led <= 1'b0;
                ovf <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------- backend read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_strobe <= 1'b0;
            rd_sel    <= 2'd0;
        end else begin
            rd_strobe <= 1'b0;
            if (rd_hit && regsel != REG_CTRL) begin
                rd_strobe <= 1'b1;
                rd_sel    <= regsel;
            end
        end
    end

endmodule
